inst_loader: RTL

Boot-time program loader that sits directly upstream of the core's instruction memory. It consumes a framed byte stream (from the UART receiver), assembles little-endian 32-bit words and drives the instruction memory's write port (`wren`/`wraddr`/`wrdata`). It also holds the core in `hold` until a frame has loaded with a valid checksum.

---
 rtl/inst_loader_if.sv | 21 ++
 rtl/inst_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - byte stream in and instruction-memory write port of the loader
interface inst_loader_if #(
    parameter int AW = 10
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wren;
    logic [AW-1:0] wraddr;
    logic [31:0]   wrdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, wren, wraddr, wrdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wren, wraddr, wrdata
    );
endinterface

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - framed byte stream to instruction-memory loader with core hold
module inst_loader #(
    parameter int InstCatchDepth = 12,
    parameter int TIMEOUT        = 100000
) (
    input  logic         clk,
    input  logic         rst,
    inst_loader_if.slave bus,
    output logic         core_hold,
    output logic         load_busy,
    output logic         load_done,
    output logic         load_err
);
    localparam int          AW        = InstCatchDepth - 2;
    localparam int unsigned MAX_WORDS = 32'd1 << AW;
    localparam int          TW        = $clog2(TIMEOUT);
    localparam logic [7:0]  MAGIC     = 8'hA5;

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    state_t        state, state_nx;
    logic          accept;
    logic          timeout_hit;
    logic [7:0]    len_l;
    logic [15:0]   len_full;
    logic          len_bad;
    logic [15:0]   len_m1;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    csum;
    logic [31:0]   word_buf;
    logic [TW-1:0] tcnt;

    assign bus.in_ready = (state != DONE) && (state != ERR);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load_busy    = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    assign timeout_hit  = load_busy && !accept && (tcnt == TW'(TIMEOUT - 1));
    assign len_full     = {bus.in_data, len_l};
    assign len_bad      = (len_full == 16'd0) || (32'(len_full) > MAX_WORDS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && bus.in_data == MAGIC) state_nx = LEN0;
            LEN0: if (accept) state_nx = LEN1;
            LEN1: if (accept) state_nx = len_bad ? ERR : DATA;
            DATA: if (accept && byte_idx == 2'd3 && word_idx == len_m1) state_nx = CSUM;
            CSUM: if (accept) state_nx = (bus.in_data == csum) ? DONE : ERR;
            DONE: state_nx = IDLE;
            ERR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A stalled source aborts the frame regardless of where it stopped
        if (timeout_hit) state_nx = ERR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wren   <= 1'b0;
            bus.wraddr <= '0;
            bus.wrdata <= '0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            len_l      <= '0;
            len_m1     <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            csum       <= '0;
            word_buf   <= '0;
            tcnt       <= '0;
        end else begin
            bus.wren <= 1'b0;

            if (load_busy && !accept) tcnt <= tcnt + 1'b1;
            else                      tcnt <= '0;

            case (state)
                IDLE: if (accept && bus.in_data == MAGIC) begin
                    load_done <= 1'b0;
                    load_err  <= 1'b0;
                    core_hold <= 1'b1;
                end
                LEN0: if (accept) len_l <= bus.in_data;
                LEN1: if (accept) begin
                    len_m1   <= len_full - 16'd1;
                    word_idx <= '0;
                    byte_idx <= '0;
                    csum     <= '0;
                end
                DATA: if (accept) begin
                    csum     <= csum ^ bus.in_data;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        bus.wren   <= 1'b1;
                        bus.wraddr <= word_idx[AW-1:0];
                        bus.wrdata <= {bus.in_data, word_buf[23:0]};
                        word_idx   <= word_idx + 16'd1;
                    end else begin
                        word_buf[{byte_idx, 3'b000} +: 8] <= bus.in_data;
                    end
                end
                DONE: begin
                    load_done <= 1'b1;
                    load_err  <= 1'b0;
                    core_hold <= 1'b0;
                end
                ERR: begin
                    load_err  <= 1'b1;
                    load_done <= 1'b0;
                    core_hold <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
